// File: rtl/tpu_ctrl_pkg.sv
// Shared types and helpers for the TPU write-side control blocks.
package tpu_ctrl_pkg;

  // Controller FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Step counter must reach L + N - 2 for the largest L, plus one spare bit.
  function automatic int step_width(input int len_w, input int n);
    return len_w + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/skewed_wr_control_skew_lane.sv
// One output-buffer column: enable and address register for lane c,
// driven from the shared step counter t of the controller.
module skew_lane
  import tpu_ctrl_pkg::*;
#(
  parameter int TW         = 11,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TW-1:0]         i_t,
  input  logic [TW-1:0]         i_lane,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic                  i_stall,
  input  logic                  i_run,
  output logic                  o_en,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic [TW-1:0] w_off;
  logic          w_hit;

  // Offset of this lane into its own write sequence; only meaningful when t >= c.
  assign w_off = i_t - i_lane;
  // Lane is active for steps c .. c+L-1; comparing the offset avoids c+L overflow.
  assign w_hit = (i_t >= i_lane) && (w_off < TW'(i_len));

  // Register enable every cycle; address only moves when the lane writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_en   <= 1'b0;
      o_addr <= '0;
    end else if (i_run && !i_stall) begin
      o_en <= w_hit;
      if (w_hit) begin
        o_addr <= i_base + ADDR_WIDTH'(w_off);
      end
    end else begin
      o_en <= 1'b0;
    end
  end

endmodule

// File: rtl/skewed_wr_control.sv
// Write-side controller for an N x N systolic array output buffer.
// Produces diagonally skewed per-column write enables and addresses.
//
// Handshake: start is sampled only in IDLE; when accepted with num_rows > 0,
// busy rises with the first step and stays high (including stall cycles)
// until the last step has been shown; done is a single-cycle pulse in the
// cycle after that, with busy already low. num_rows == 0 produces done in the
// cycle after start without ever raising busy. A new start may be sampled on
// the same edge that raises done.
module skewed_wr_control
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [LEN_WIDTH-1:0]               num_rows,
  input  logic                               stall,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH_HEIGHT-1:0]            wr_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr,
  output state_e                             o_dbg_state
);

  localparam int TW = step_width(LEN_WIDTH, WIDTH_HEIGHT);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [TW-1:0]         r_t;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_last;
  logic                  w_run;
  logic [ADDR_WIDTH-1:0] w_lane_addr [WIDTH_HEIGHT];

  // Final step is t = L + N - 2 (wraps correctly for N = 1).
  assign w_last = (r_t == (TW'(r_len) + TW'(WIDTH_HEIGHT - 2)));
  assign w_run  = (r_state == ST_RUN);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus next busy/done flags.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // r_busy still high here means the previous edge emitted the last step.
        w_done_nxt = r_busy || (start && (num_rows == '0));
        if (start && (num_rows != '0)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_busy_nxt = 1'b1;
        if (!stall && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Step counter, latched parameters and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t    <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_base <= base_addr;
          r_len  <= num_rows;
          r_t    <= '0;
        end
      end else if (!stall) begin
        r_t <= r_t + TW'(1);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < WIDTH_HEIGHT; g++) begin : g_lane
      skew_lane #(
        .TW         (TW),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .i_t     (r_t),
        .i_lane  (TW'(g)),
        .i_len   (r_len),
        .i_base  (r_base),
        .i_stall (stall),
        .i_run   (w_run),
        .o_en    (wr_en[g]),
        .o_addr  (w_lane_addr[g])
      );
      assign wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = w_lane_addr[g];
    end
  endgenerate

  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_skewed_wr_control.sv
// Bench for skewed_wr_control: directed test-plan vectors plus randomized
// transfers checked against a step-arithmetic reference model.
module tb_skewed_wr_control;
  import tpu_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int N8 = 8;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int W  = 2 + N + N * AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // N = 4 instance signals
  logic            start, stall;
  logic [AW-1:0]   base_addr;
  logic [LW-1:0]   num_rows;
  logic            busy, done;
  logic [N-1:0]    wr_en;
  logic [N*AW-1:0] wr_addr;
  state_e          dbg_state;

  // N = 8 instance signals
  logic             start8, stall8;
  logic [AW-1:0]    base8;
  logic [LW-1:0]    rows8;
  logic             busy8, done8;
  logic [N8-1:0]    wr_en8;
  logic [N8*AW-1:0] wr_addr8;
  state_e           dbg_state8;

  skewed_wr_control #(.WIDTH_HEIGHT(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .stall(stall), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .o_dbg_state(dbg_state)
  );

  skewed_wr_control #(.WIDTH_HEIGHT(N8), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .base_addr(base8),
    .num_rows(rows8), .stall(stall8), .busy(busy8), .done(done8),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .o_dbg_state(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr [N];   // address each lane currently holds

  // ---------------- scenario driver + model ----------------
  // Builds the expected per-cycle trace from step arithmetic, then drives and compares.
  task automatic run_xfer(input string name, input logic [AW-1:0] b, input int len,
                          input int stall_pct, input bit mid_start, input bit chain,
                          input bit already, input logic [AW-1:0] nb, input int nlen);
    logic [AW-1:0]   a [N];
    logic [N-1:0]    en;
    logic [N*AW-1:0] pa;
    logic [W-1:0]    got, exp_v;
    bit              stv[$];
    bit              st;
    int              emitted, j;
    for (int c = 0; c < N; c++) a[c] = exp_addr[c];
    pa = '0;
    for (int c = 0; c < N; c++) pa[c*AW +: AW] = a[c];
    exp_q.delete();
    emitted = 0;
    while (emitted < len + N - 1) begin
      st = (stv.size() < 200) && ($urandom_range(99) < stall_pct);
      stv.push_back(st);
      en = '0;
      if (!st) begin
        for (int c = 0; c < N; c++)
          if (emitted >= c && emitted < c + len) begin
            en[c] = 1'b1;
            a[c]  = b + AW'(emitted - c);
          end
        emitted++;
      end
      for (int c = 0; c < N; c++) pa[c*AW +: AW] = a[c];
      exp_q.push_back({1'b0, 1'b1, en, pa});
    end
    stv.push_back($urandom_range(1) == 1);   // done cycle: stall must be ignored
    exp_q.push_back({1'b1, 1'b0, {N{1'b0}}, pa});

    if (!already) begin
      @(negedge clk);
      start = 1'b1; base_addr = b; num_rows = LW'(len); stall = 1'($urandom);
      @(posedge clk); #1;
    end
    j = 0;
    while (exp_q.size() > 0) begin
      j++;
      @(negedge clk);
      start = 1'b0; stall = stv.pop_front();
      base_addr = AW'($urandom); num_rows = LW'($urandom);
      if (mid_start && j == 3) start = 1'b1;
      if (chain && exp_q.size() == 1) begin
        start = 1'b1; base_addr = nb; num_rows = LW'(nlen);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got   = {done, busy, wr_en, wr_addr};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d: got=%h exp=%h", name, j, got, exp_v);
      end
    end
    for (int c = 0; c < N; c++) exp_addr[c] = a[c];
    if (!chain) begin
      @(negedge clk); start = 1'b0; stall = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if ({done, busy, wr_en} !== {2'b00, {N{1'b0}}} || wr_addr !== pa) begin
        bad++;
        $display("FAIL %s idle: got=%h exp=%h", name, {done, busy, wr_en, wr_addr},
                 {2'b00, {N{1'b0}}, pa});
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    start = 0; stall = 0; base_addr = '0; num_rows = '0;
    start8 = 0; stall8 = 0; base8 = '0; rows8 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({done, busy, wr_en, wr_addr} !== '0) begin
      bad++; $display("FAIL reset_out: got=%h exp=0", {done, busy, wr_en, wr_addr});
    end
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
    total++;
    if ({done8, busy8, wr_en8, wr_addr8} !== '0) begin
      bad++; $display("FAIL reset_out8: got=%h exp=0", {done8, busy8, wr_en8, wr_addr8});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < N; c++) exp_addr[c] = '0;
  endtask

  task automatic test_directed();
    logic [N-1:0]  tbl [8];
    logic [AW-1:0] ea;
    tbl = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    @(negedge clk); start = 1'b1; base_addr = 8'h10; num_rows = 8'd4; stall = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      total++;
      if (wr_en !== tbl[cyc-1] || done !== (cyc == 8) || busy !== (cyc <= 7)) begin
        bad++;
        $display("FAIL directed c%0d: en=%h done=%b busy=%b exp en=%h done=%b busy=%b",
                 cyc, wr_en, done, busy, tbl[cyc-1], (cyc == 8), (cyc <= 7));
      end
      if (cyc <= 4) begin
        ea = 8'h10 + AW'(cyc - 1);
        total++;
        if (wr_addr[0 +: AW] !== ea) begin
          bad++; $display("FAIL directed_col0 c%0d: got=%h exp=%h", cyc, wr_addr[0 +: AW], ea);
        end
      end
      if (cyc >= 4 && cyc <= 7) begin
        ea = 8'h10 + AW'(cyc - 4);
        total++;
        if (wr_addr[3*AW +: AW] !== ea) begin
          bad++; $display("FAIL directed_col3 c%0d: got=%h exp=%h", cyc, wr_addr[3*AW +: AW], ea);
        end
      end
    end
    for (int c = 0; c < N; c++) exp_addr[c] = 8'h13;
  endtask

  task automatic test_stall_directed();
    logic [N-1:0] tbl [9];
    tbl = '{4'h1, 4'h3, 4'h0, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    @(negedge clk); start = 1'b1; base_addr = 8'h10; num_rows = 8'd4; stall = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk); start = 1'b0; stall = (cyc == 3);
      @(posedge clk); #1;
      total++;
      if (wr_en !== tbl[cyc-1] || done !== (cyc == 9)) begin
        bad++;
        $display("FAIL stall_dir c%0d: en=%h done=%b exp en=%h done=%b",
                 cyc, wr_en, done, tbl[cyc-1], (cyc == 9));
      end
      if (cyc == 3) begin
        total++;
        if (wr_addr[0 +: AW] !== 8'h11 || wr_addr[AW +: AW] !== 8'h10) begin
          bad++;
          $display("FAIL stall_hold: col0=%h col1=%h exp col0=11 col1=10",
                   wr_addr[0 +: AW], wr_addr[AW +: AW]);
        end
      end
    end
    stall = 1'b0;
    for (int c = 0; c < N; c++) exp_addr[c] = 8'h13;
  endtask

  task automatic test_wrap();
    run_xfer("wrap", 8'hFE, 4, 0, 1'b0, 1'b0, 1'b0, '0, 0);
    total++;
    if (wr_addr[0 +: AW] !== 8'h01 || wr_addr[3*AW +: AW] !== 8'h01) begin
      bad++;
      $display("FAIL wrap_final: col0=%h col3=%h exp 01 01", wr_addr[0 +: AW], wr_addr[3*AW +: AW]);
    end
  endtask

  task automatic test_zero_len();
    logic [N*AW-1:0] pa;
    for (int c = 0; c < N; c++) pa[c*AW +: AW] = exp_addr[c];
    @(negedge clk);
    start = 1'b1; num_rows = '0; base_addr = AW'($urandom); stall = 1'($urandom);
    @(posedge clk); #1;
    total++;
    if ({done, busy, wr_en} !== {2'b10, {N{1'b0}}} || wr_addr !== pa || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL zero_len: got=%h exp=%h state=%0d", {done, busy, wr_en, wr_addr},
               {2'b10, {N{1'b0}}, pa}, dbg_state);
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({done, busy, wr_en} !== {2'b00, {N{1'b0}}}) begin
      bad++; $display("FAIL zero_len_after: got=%b exp=0", {done, busy, wr_en});
    end
  endtask

  task automatic test_mid_start();
    run_xfer("mid_start", AW'($urandom), 4, 0, 1'b1, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1; base_addr = 8'h55; num_rows = 8'd4; stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (wr_en !== 4'hF || busy !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre: en=%h busy=%b exp en=f busy=1", wr_en, busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({done, busy, wr_en, wr_addr} !== '0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_mid: got=%h state=%0d exp=0", {done, busy, wr_en, wr_addr}, dbg_state);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if ({done, busy, wr_en} !== '0) begin
        bad++; $display("FAIL reset_mid_after %0d: got=%b exp=0", i, {done, busy, wr_en});
      end
    end
    for (int c = 0; c < N; c++) exp_addr[c] = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_xfer("random", AW'($urandom), $urandom_range(1, 12), 30, 1'b0, 1'b0, 1'b0, '0, 0);
    run_xfer("random_long", AW'($urandom), 200, 10, 1'b0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] b2;
    int            l2;
    b2 = AW'($urandom);
    l2 = $urandom_range(1, 6);
    run_xfer("b2b_first", AW'($urandom), $urandom_range(1, 6), 20, 1'b0, 1'b1, 1'b0, b2, l2);
    run_xfer("b2b_second", b2, l2, 0, 1'b0, 1'b0, 1'b1, '0, 0);
  endtask

  task automatic test_n8();
    logic [N8-1:0] en;
    logic [N8-1:0] ramp [4];
    ramp = '{8'h01, 8'h03, 8'h06, 8'h0C};
    @(negedge clk); start8 = 1'b1; base8 = 8'h40; rows8 = 8'd2; stall8 = 1'b0;
    @(posedge clk); #1;
    for (int run = 0; run < 2; run++) begin
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(negedge clk);
        start8 = (run == 0 && cyc == 10);
        if (start8) base8 = 8'h80;
        @(posedge clk); #1;
        en = '0;
        for (int c = 0; c < N8; c++)
          if (cyc - 1 >= c && cyc - 1 < c + 2 && cyc <= 9) en[c] = 1'b1;
        total++;
        if (wr_en8 !== en || done8 !== (cyc == 10) || busy8 !== (cyc <= 9)) begin
          bad++;
          $display("FAIL n8 run%0d c%0d: en=%h done=%b busy=%b exp en=%h done=%b busy=%b",
                   run, cyc, wr_en8, done8, busy8, en, (cyc == 10), (cyc <= 9));
        end
        if (cyc <= 4) begin
          total++;
          if (wr_en8 !== ramp[cyc-1]) begin
            bad++; $display("FAIL n8_ramp c%0d: got=%h exp=%h", cyc, wr_en8, ramp[cyc-1]);
          end
        end
        if (cyc == 1) begin
          total++;
          if (wr_addr8[0 +: AW] !== (run == 0 ? 8'h40 : 8'h80)) begin
            bad++; $display("FAIL n8_addr0 run%0d: got=%h", run, wr_addr8[0 +: AW]);
          end
        end
        if (cyc == 9) begin
          total++;
          if (wr_addr8[7*AW +: AW] !== (run == 0 ? 8'h41 : 8'h81)) begin
            bad++; $display("FAIL n8_addr7 run%0d: got=%h", run, wr_addr8[7*AW +: AW]);
          end
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_stall_directed();
    test_wrap();
    test_zero_len();
    test_mid_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_n8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
